// File: rtl/daw_pkg.sv
// Shared audio-effect types and default widths.
package daw_pkg;

    localparam int DEFAULT_WIDTH    = 16;
    localparam int DEFAULT_CHANNELS = 2;
    localparam int DEFAULT_HOLD_W   = 8;

    typedef enum logic [1:0] {
        MODE_BYPASS     = 2'b00,
        MODE_CRUSH      = 2'b01,
        MODE_CLIP       = 2'b10,
        MODE_CRUSH_CLIP = 2'b11
    } crush_mode_t;

endpackage

// File: rtl/crush_channel.sv
// Combinational bit-crush and symmetric clip for a single signed sample.
module crush_channel
    import daw_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                        active,
    input  crush_mode_t                 mode,
    input  logic [$clog2(WIDTH)-1:0]    crush_bits,
    input  logic [WIDTH-2:0]            clip_level,
    input  logic signed [WIDTH-1:0]     sample,
    output logic signed [WIDTH-1:0]     result
);

    localparam int CB_W = $clog2(WIDTH);
    localparam logic [CB_W-1:0] MAX_SHIFT = CB_W'(WIDTH - 1);

    logic [CB_W-1:0]          shift;
    logic [WIDTH-1:0]         mask;
    logic signed [WIDTH-1:0]  crushed;
    logic signed [WIDTH-1:0]  clip_src;
    logic signed [WIDTH-1:0]  clipped;
    logic signed [WIDTH-1:0]  pos_lim;
    logic signed [WIDTH-1:0]  neg_lim;

    always_comb begin
        shift = crush_bits;
        if (crush_bits > MAX_SHIFT) begin
            shift = MAX_SHIFT;
        end
        mask    = {WIDTH{1'b1}} << shift;
        crushed = sample & mask;

        // Clip input is the crushed value only in the chained mode.
        clip_src = (mode == MODE_CRUSH_CLIP) ? crushed : sample;
        pos_lim  = $signed({1'b0, clip_level});
        neg_lim  = -pos_lim;
        clipped  = clip_src;
        if (clip_src > pos_lim) begin
            clipped = pos_lim;
        end else if (clip_src < neg_lim) begin
            clipped = neg_lim;
        end

        result = sample;
        if (active) begin
            case (mode)
                MODE_CRUSH:      result = crushed;
                MODE_CLIP:       result = clipped;
                MODE_CRUSH_CLIP: result = clipped;
                default:         result = sample;
            endcase
        end
    end

endmodule

// File: rtl/bitcrusher.sv
// Multichannel bitcrusher: sample-hold decimation stage followed by a
// registered crush/clip stage.
module bitcrusher
    import daw_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int HOLD_W   = DEFAULT_HOLD_W
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        enable,
    input  logic [1:0]                  mode,
    input  logic [$clog2(WIDTH)-1:0]    crush_bits,
    input  logic [WIDTH-2:0]            clip_level,
    input  logic [HOLD_W-1:0]           hold_count,
    input  logic                        valid_in,
    input  logic [CHANNELS*WIDTH-1:0]   data_in,
    output logic                        valid_out,
    output logic [CHANNELS*WIDTH-1:0]   data_out
);

    // valid_in and valid_out are single-cycle strobes with no ready:
    // every valid_in beat produces exactly one valid_out beat two cycles later.

    logic [CHANNELS*WIDTH-1:0] hold_reg;
    logic [HOLD_W-1:0]         hold_cnt;
    logic                      s1_valid;
    logic [CHANNELS*WIDTH-1:0] processed;
    logic                      active;
    crush_mode_t               mode_e;

    assign mode_e = crush_mode_t'(mode);
    assign active = enable && (mode_e != MODE_BYPASS);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            hold_reg <= '0;
            hold_cnt <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= valid_in;
            if (!enable) begin
                hold_cnt <= '0;
                if (valid_in) begin
                    hold_reg <= data_in;
                end
            end else if (valid_in) begin
                // hold_count is only looked at on reload, so mid-hold edits wait.
                if (hold_cnt == '0) begin
                    hold_reg <= data_in;
                    hold_cnt <= hold_count;
                end else begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
            end
        end
    end

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        crush_channel #(
            .WIDTH (WIDTH)
        ) u_crush (
            .active     (active),
            .mode       (mode_e),
            .crush_bits (crush_bits),
            .clip_level (clip_level),
            .sample     (hold_reg[ch*WIDTH +: WIDTH]),
            .result     (processed[ch*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= s1_valid;
            if (s1_valid) begin
                data_out <= processed;
            end
        end
    end

endmodule
